// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped 8N1 UART transmitter fed by a small circular TX FIFO.
// CPU writes push bytes; the serialiser pops one byte per frame and drives uart_tx.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 104
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          div_we,
  input  logic [DIV_WIDTH-1:0]          div_data,
  input  logic                          clr_ovf,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]        DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = DIV_WIDTH'(0);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 ovf_q;
  logic                 full_s, empty_s, push_s, pop_s;

  // Divisor and serialiser state
  logic [DIV_WIDTH-1:0] div_q;
  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] timer_q, timer_d;
  logic [DIV_WIDTH-1:0] fdiv_q, fdiv_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 load_s;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == {CW{1'b0}});
  // Full is judged before any same-cycle pop, so a write at full is always dropped.
  assign push_s  = wr_en & ~full_s;

  // FIFO pointers, storage, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (wr_en && full_s) ovf_q <= 1'b1;
      else if (clr_ovf)    ovf_q <= 1'b0;
    end
  end

  // Baud divisor register; zero is stored as one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div_q <= DIV_RST;
    else if (div_we) div_q <= (div_data == DIV_ZERO) ? DIV_ONE : div_data;
  end

  // Next-state logic of the serialiser; load_s marks a frame start (pop)
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fdiv_d  = fdiv_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    load_s  = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty_s) load_s = 1'b1;
        else          state_d = S_IDLE;
      end
      S_START: begin
        if (timer_q == DIV_ZERO) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          timer_d = fdiv_q - DIV_ONE;
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      S_DATA: begin
        if (timer_q == DIV_ZERO) begin
          timer_d = fdiv_q - DIV_ONE;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      S_STOP: begin
        if (timer_q == DIV_ZERO) begin
          if (!empty_s) begin
            load_s = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // A frame start pops the head byte and latches the divisor for the whole frame.
    if (load_s) begin
      pop_s   = 1'b1;
      shift_d = mem_q[rd_ptr_q];
      fdiv_d  = div_q;
      timer_d = div_q - DIV_ONE;
      tx_d    = 1'b0;
      state_d = S_START;
    end else begin
      pop_s   = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // Serialiser state register with registered line and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= DIV_ZERO;
      fdiv_q  <= DIV_RST;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fdiv_q  <= fdiv_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_tx    = tx_q;
  assign tx_busy    = busy_q;
  assign fifo_full  = full_s;
  assign fifo_empty = empty_s;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
